// File: rtl/ysyx_22040386_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 access
// encodings and the per-size byte-strobe patterns.
package ysyx_22040386_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_D  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;
    localparam logic [2:0] MEMOP_WU = 3'b110;

    localparam logic [7:0] SZ_MASK_B = 8'h01;
    localparam logic [7:0] SZ_MASK_H = 8'h03;
    localparam logic [7:0] SZ_MASK_W = 8'h0F;
    localparam logic [7:0] SZ_MASK_D = 8'hFF;

    // Encoding 3'b111 has no defined size and is handled as a doubleword.
    function automatic logic [7:0] size_mask(input logic [2:0] op);
        case (op)
            MEMOP_B, MEMOP_BU: size_mask = SZ_MASK_B;
            MEMOP_H, MEMOP_HU: size_mask = SZ_MASK_H;
            MEMOP_W, MEMOP_WU: size_mask = SZ_MASK_W;
            default:           size_mask = SZ_MASK_D;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040386_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
// Handshakes: a request transfers on a cycle where dmem_req_valid && dmem_req_ready,
// and the master holds every request field stable until then; dmem_resp_valid is a
// single-cycle pulse with no ready, carrying load data or a store acknowledge.
interface ysyx_22040386_lsu_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_req_addr;
    logic        dmem_req_wen;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_wmask;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_data;

    modport master (
        output dmem_req_valid, dmem_req_addr, dmem_req_wen, dmem_req_wdata, dmem_req_wmask,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );

    modport slave (
        input  dmem_req_valid, dmem_req_addr, dmem_req_wen, dmem_req_wdata, dmem_req_wmask,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );
endinterface

// File: rtl/ysyx_22040386_lsu_align.sv
// Combinational sub-word handling: store-data lane shift, byte strobe, load
// extraction with sign/zero extension, and natural-alignment check.
module ysyx_22040386_lsu_align
    import ysyx_22040386_lsu_pkg::*;
(
    input  logic [2:0]  i_memop,
    input  logic [2:0]  i_addr_lo,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_resp_data,
    output logic [63:0] o_wdata_sh,
    output logic [7:0]  o_wmask,
    output logic [63:0] o_load_ext,
    output logic        o_misalign
);
    logic [5:0]  w_bit_off;
    logic [63:0] w_sh;

    assign w_bit_off  = {i_addr_lo, 3'b000};
    assign w_sh       = i_resp_data >> w_bit_off;
    assign o_wdata_sh = i_wdata << w_bit_off;
    assign o_wmask    = size_mask(i_memop) << i_addr_lo;

    always_comb begin
        o_load_ext = w_sh;
        o_misalign = 1'b0;
        case (i_memop)
            MEMOP_B:  o_load_ext = {{56{w_sh[7]}}, w_sh[7:0]};
            MEMOP_BU: o_load_ext = {56'd0, w_sh[7:0]};
            MEMOP_H: begin
                o_load_ext = {{48{w_sh[15]}}, w_sh[15:0]};
                o_misalign = i_addr_lo[0];
            end
            MEMOP_HU: begin
                o_load_ext = {48'd0, w_sh[15:0]};
                o_misalign = i_addr_lo[0];
            end
            MEMOP_W: begin
                o_load_ext = {{32{w_sh[31]}}, w_sh[31:0]};
                o_misalign = |i_addr_lo[1:0];
            end
            MEMOP_WU: begin
                o_load_ext = {32'd0, w_sh[31:0]};
                o_misalign = |i_addr_lo[1:0];
            end
            default: begin
                o_load_ext = w_sh;
                o_misalign = |i_addr_lo;
            end
        endcase
    end
endmodule

// File: rtl/ysyx_22040386_lsu.sv
// Load/store unit after execute: one memory transaction per instruction, with a
// bypass for non-memory results, an alignment trap and an optional response watchdog.
module ysyx_22040386_lsu
    import ysyx_22040386_lsu_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       MemRead,
    input  logic                       MemWrite,
    input  logic [2:0]                 MemOp,
    input  logic [63:0]                addr,
    input  logic [63:0]                wdata,
    ysyx_22040386_lsu_if.master        dmem,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                rdata,
    output logic                       misalign,
    output logic                       err,
    output lsu_state_e                 o_state
);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       r_state, w_state_nxt;
    logic             r_is_store, w_is_store_nxt;
    logic [2:0]       r_memop, w_memop_nxt;
    logic [63:0]      r_addr, w_addr_nxt;
    logic [63:0]      r_wdata, w_wdata_nxt;
    logic [63:0]      r_rdata, w_rdata_nxt;
    logic             r_misalign, w_misalign_nxt;
    logic             r_err, w_err_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic             w_idle, w_in_req, w_store_req;
    logic [2:0]       w_op, w_lo;
    logic [63:0]      w_wdata_sh, w_load_ext;
    logic [7:0]       w_wmask;
    logic             w_misalign;

    assign w_idle      = (r_state == IDLE);
    assign w_in_req    = (r_state == REQ);
    assign w_store_req = w_in_req && r_is_store;

    // In IDLE the aligner checks the incoming instruction; afterwards it works on the latched copy.
    assign w_op = w_idle ? MemOp      : r_memop;
    assign w_lo = w_idle ? addr[2:0]  : r_addr[2:0];

    ysyx_22040386_lsu_align u_align (
        .i_memop     (w_op),
        .i_addr_lo   (w_lo),
        .i_wdata     (r_wdata),
        .i_resp_data (dmem.dmem_resp_data),
        .o_wdata_sh  (w_wdata_sh),
        .o_wmask     (w_wmask),
        .o_load_ext  (w_load_ext),
        .o_misalign  (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_is_store <= 1'b0;
            r_memop    <= 3'd0;
            r_addr     <= 64'd0;
            r_wdata    <= 64'd0;
            r_rdata    <= 64'd0;
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_is_store <= w_is_store_nxt;
            r_memop    <= w_memop_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rdata    <= w_rdata_nxt;
            r_misalign <= w_misalign_nxt;
            r_err      <= w_err_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_is_store_nxt = r_is_store;
        w_memop_nxt    = r_memop;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_rdata_nxt    = r_rdata;
        w_misalign_nxt = r_misalign;
        w_err_nxt      = r_err;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_is_store_nxt = MemWrite;
                    w_memop_nxt    = MemOp;
                    w_addr_nxt     = addr;
                    w_wdata_nxt    = wdata;
                    if (!MemRead && !MemWrite) begin
                        w_rdata_nxt = addr;
                        w_state_nxt = DONE;
                    end else if (w_misalign) begin
                        w_misalign_nxt = 1'b1;
                        w_rdata_nxt    = 64'd0;
                        w_state_nxt    = DONE;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_req_ready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the timeout cycle takes priority over the abort.
                if (dmem.dmem_resp_valid) begin
                    w_rdata_nxt = r_is_store ? 64'd0 : w_load_ext;
                    w_state_nxt = DONE;
                end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = 64'd0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_rdata_nxt    = 64'd0;
                    w_misalign_nxt = 1'b0;
                    w_err_nxt      = 1'b0;
                    w_state_nxt    = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign in_ready            = w_idle;
    assign out_valid           = (r_state == DONE);
    assign rdata               = r_rdata;
    assign misalign            = r_misalign;
    assign err                 = r_err;
    assign o_state             = r_state;
    assign dmem.dmem_req_valid = w_in_req;
    assign dmem.dmem_req_addr  = w_in_req ? {r_addr[63:3], 3'b000} : 64'd0;
    assign dmem.dmem_req_wen   = w_store_req;
    assign dmem.dmem_req_wdata = w_store_req ? w_wdata_sh : 64'd0;
    assign dmem.dmem_req_wmask = w_store_req ? w_wmask : 8'd0;
endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Directed bench for the LSU: bypass, loads, stores with backpressure, alignment
// trap, watchdog timeout, reset mid-transaction and output stall.
module tb_ysyx_22040386_lsu;
    import ysyx_22040386_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        MemRead, MemWrite;
    logic [2:0]  MemOp;
    logic [63:0] addr, wdata;
    logic        out_valid, out_ready;
    logic [63:0] rdata;
    logic        misalign, err;
    lsu_state_e  o_state;
    int          n_tests = 0;
    int          n_fail  = 0;

    ysyx_22040386_lsu_if dmem_if ();

    ysyx_22040386_lsu #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemOp(MemOp), .addr(addr), .wdata(wdata),
        .dmem(dmem_if.master), .out_valid(out_valid), .out_ready(out_ready), .rdata(rdata),
        .misalign(misalign), .err(err), .o_state(o_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] d);
        in_valid = 1'b1; MemRead = rd; MemWrite = wr; MemOp = op; addr = a; wdata = d;
        step();
        in_valid = 1'b0; MemRead = ~rd; MemWrite = 1'b0; MemOp = ~op; addr = ~a; wdata = ~d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_tests++;
        if ({in_ready, dmem_if.dmem_req_valid, dmem_if.dmem_req_wen, out_valid, misalign, err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b exp 100000",
                     {in_ready, dmem_if.dmem_req_valid, dmem_if.dmem_req_wen, out_valid, misalign, err});
        end
        n_tests++;
        if ({rdata, dmem_if.dmem_req_addr, dmem_if.dmem_req_wdata, dmem_if.dmem_req_wmask} !== 200'd0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata %h addr %h wdata %h wmask %h exp all zero",
                     rdata, dmem_if.dmem_req_addr, dmem_if.dmem_req_wdata, dmem_if.dmem_req_wmask);
        end
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        dmem_if.dmem_req_ready = 1'b1;
        issue(1'b0, 1'b0, 3'b011, 64'h8000_0010, 64'h55);
        n_tests++;
        if ({out_valid, dmem_if.dmem_req_valid, misalign, err} !== 4'b1000 || rdata !== 64'h8000_0010) begin
            n_fail++;
            $display("FAIL bypass: got v=%b req=%b mis=%b err=%b rdata=%h exp v=1 req=0 mis=0 err=0 rdata=80000010",
                     out_valid, dmem_if.dmem_req_valid, misalign, err, rdata);
        end
        step();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bypass_release: got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_load_byte();
        logic [63:0] exp_r [2];
        exp_r[0] = 64'hFFFF_FFFF_FFFF_FF80;
        exp_r[1] = 64'h0000_0000_0000_0080;
        out_ready = 1'b1;
        dmem_if.dmem_req_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue(1'b1, 1'b0, (k == 0) ? MEMOP_B : MEMOP_BU, 64'h8000_0005, 64'hDEAD);
            n_tests++;
            if ({dmem_if.dmem_req_valid, dmem_if.dmem_req_wen, dmem_if.dmem_req_wmask} !== 10'b10_0000_0000
                || dmem_if.dmem_req_addr !== 64'h8000_0000) begin
                n_fail++;
                $display("FAIL load_req[%0d]: got v=%b wen=%b wmask=%h addr=%h exp v=1 wen=0 wmask=00 addr=80000000",
                         k, dmem_if.dmem_req_valid, dmem_if.dmem_req_wen, dmem_if.dmem_req_wmask, dmem_if.dmem_req_addr);
            end
            step();
            n_tests++;
            if ({dmem_if.dmem_req_valid, out_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL load_wait[%0d]: got req_valid=%b out_valid=%b exp 0 0", k, dmem_if.dmem_req_valid, out_valid);
            end
            dmem_if.dmem_resp_valid = 1'b1;
            dmem_if.dmem_resp_data  = 64'h0000_8000_0000_0000;
            step();
            dmem_if.dmem_resp_valid = 1'b0;
            dmem_if.dmem_resp_data  = 64'h0;
            n_tests++;
            if (out_valid !== 1'b1 || rdata !== exp_r[k]) begin
                n_fail++;
                $display("FAIL load_data[%0d]: got v=%b rdata=%h exp v=1 rdata=%h", k, out_valid, rdata, exp_r[k]);
            end
            step();
        end
    endtask

    task automatic test_store_half();
        logic [137:0] exp_req;
        exp_req = {1'b1, 1'b1, 8'hC0, 64'h8000_0000, 64'h1234_0000_0000_0000};
        out_ready = 1'b1;
        dmem_if.dmem_req_ready = 1'b0;
        issue(1'b0, 1'b1, MEMOP_H, 64'h8000_0006, 64'h1234);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({dmem_if.dmem_req_valid, dmem_if.dmem_req_wen, dmem_if.dmem_req_wmask,
                 dmem_if.dmem_req_addr, dmem_if.dmem_req_wdata} !== exp_req) begin
                n_fail++;
                $display("FAIL store_req[%0d]: got v=%b wen=%b wmask=%h addr=%h wdata=%h exp v=1 wen=1 wmask=c0 addr=80000000 wdata=1234000000000000",
                         i, dmem_if.dmem_req_valid, dmem_if.dmem_req_wen, dmem_if.dmem_req_wmask,
                         dmem_if.dmem_req_addr, dmem_if.dmem_req_wdata);
            end
            if (i == 3) dmem_if.dmem_req_ready = 1'b1;
            step();
        end
        dmem_if.dmem_req_ready = 1'b0;
        n_tests++;
        if (dmem_if.dmem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_drop_req: got req_valid=%b exp 0", dmem_if.dmem_req_valid);
        end
        dmem_if.dmem_resp_valid = 1'b1;
        dmem_if.dmem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        dmem_if.dmem_resp_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || rdata !== 64'd0) begin
            n_fail++;
            $display("FAIL store_ack: got v=%b rdata=%h exp v=1 rdata=0", out_valid, rdata);
        end
        step();
    endtask

    task automatic test_misalign();
        out_ready = 1'b1;
        dmem_if.dmem_req_ready = 1'b1;
        issue(1'b1, 1'b0, MEMOP_W, 64'h8000_0002, 64'h0);
        n_tests++;
        if ({out_valid, misalign, err, dmem_if.dmem_req_valid} !== 4'b1100 || rdata !== 64'd0) begin
            n_fail++;
            $display("FAIL misalign: got v=%b mis=%b err=%b req=%b rdata=%h exp v=1 mis=1 err=0 req=0 rdata=0",
                     out_valid, misalign, err, dmem_if.dmem_req_valid, rdata);
        end
        step();
        n_tests++;
        if ({out_valid, misalign} !== 2'b00) begin
            n_fail++;
            $display("FAIL misalign_clear: got v=%b mis=%b exp 0 0", out_valid, misalign);
        end
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        dmem_if.dmem_req_ready = 1'b1;
        issue(1'b1, 1'b0, MEMOP_D, 64'h8000_0008, 64'h0);
        step();
        dmem_if.dmem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early[%0d]: got out_valid=%b exp 0", i, out_valid);
            end
            step();
        end
        n_tests++;
        if ({out_valid, err, misalign} !== 3'b110 || rdata !== 64'd0) begin
            n_fail++;
            $display("FAIL timeout_err: got v=%b err=%b mis=%b rdata=%h exp v=1 err=1 mis=0 rdata=0",
                     out_valid, err, misalign, rdata);
        end
        step();
        dmem_if.dmem_resp_valid = 1'b1;
        dmem_if.dmem_resp_data  = 64'h1111_2222_3333_4444;
        step();
        dmem_if.dmem_resp_valid = 1'b0;
        n_tests++;
        if ({out_valid, err, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL late_resp: got v=%b err=%b in_ready=%b exp 0 0 1", out_valid, err, in_ready);
        end
    endtask

    task automatic test_timeout_race();
        out_ready = 1'b1;
        dmem_if.dmem_req_ready = 1'b1;
        issue(1'b1, 1'b0, MEMOP_D, 64'h8000_0018, 64'h0);
        step();
        dmem_if.dmem_req_ready = 1'b0;
        step(); step(); step();
        dmem_if.dmem_resp_valid = 1'b1;
        dmem_if.dmem_resp_data  = 64'hCAFE_F00D_1234_5678;
        step();
        dmem_if.dmem_resp_valid = 1'b0;
        n_tests++;
        if ({out_valid, err} !== 2'b10 || rdata !== 64'hCAFE_F00D_1234_5678) begin
            n_fail++;
            $display("FAIL timeout_race: got v=%b err=%b rdata=%h exp v=1 err=0 rdata=cafef00d12345678",
                     out_valid, err, rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        out_ready = 1'b1;
        dmem_if.dmem_req_ready = 1'b1;
        issue(1'b0, 1'b1, MEMOP_D, 64'h8000_0010, 64'hABCD);
        step();
        dmem_if.dmem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if ({in_ready, out_valid, dmem_if.dmem_req_valid, dmem_if.dmem_req_wen, err, misalign} !== 6'b100000
            || rdata !== 64'd0 || dmem_if.dmem_req_wmask !== 8'd0 || o_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got in_ready=%b v=%b req=%b wen=%b err=%b mis=%b rdata=%h wmask=%h exp 1 0 0 0 0 0 0 00",
                     in_ready, out_valid, dmem_if.dmem_req_valid, dmem_if.dmem_req_wen, err, misalign,
                     rdata, dmem_if.dmem_req_wmask);
        end
        dmem_if.dmem_resp_valid = 1'b1;
        step();
        dmem_if.dmem_resp_valid = 1'b0;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL resp_after_reset: got v=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        dmem_if.dmem_req_ready = 1'b1;
        issue(1'b1, 1'b0, MEMOP_WU, 64'h8000_0004, 64'h0);
        step();
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_resp_valid = 1'b1;
        dmem_if.dmem_resp_data  = 64'h8765_4321_0000_0000;
        step();
        dmem_if.dmem_resp_valid = 1'b0;
        dmem_if.dmem_resp_data  = 64'h0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({out_valid, in_ready} !== 2'b10 || rdata !== 64'h0000_0000_8765_4321) begin
                n_fail++;
                $display("FAIL stall[%0d]: got v=%b in_ready=%b rdata=%h exp v=1 in_ready=0 rdata=0000000087654321",
                         i, out_valid, in_ready, rdata);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        issue(1'b0, 1'b0, 3'b000, 64'h0000_0000_1111_0000, 64'h0);
        in_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = 64'h0000_0000_2222_0000;
        n_tests++;
        if (out_valid !== 1'b1 || rdata !== 64'h0000_0000_1111_0000) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%b rdata=%h exp v=1 rdata=11110000", out_valid, rdata);
        end
        step();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_gap: got v=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        addr = 64'h0;
        n_tests++;
        if (out_valid !== 1'b1 || rdata !== 64'h0000_0000_2222_0000) begin
            n_fail++;
            $display("FAIL b2b_second: got v=%b rdata=%h exp v=1 rdata=22220000", out_valid, rdata);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemOp = 3'd0;
        addr = 64'd0; wdata = 64'd0; out_ready = 1'b0;
        dmem_if.dmem_req_ready  = 1'b0;
        dmem_if.dmem_resp_valid = 1'b0;
        dmem_if.dmem_resp_data  = 64'd0;
        test_reset();
        test_bypass();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_timeout();
        test_timeout_race();
        test_reset_mid_wait();
        test_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22040386_lsu.md
Name: ysyx_22040386_lsu

Overview:
- Load/store unit directly downstream of the execute stage.
- Consumes the execute result (effective address, or the plain ALU/link result for non-memory instructions) and the rs2 value as store data.
- Performs one data-memory transaction per instruction over a valid/ready request/response interface, with sub-word alignment, byte masking and sign/zero extension.
- Hands a single 64-bit writeback value to the writeback stage through a valid/ready output.

Parameters:
- TIMEOUT, 0, cycles allowed in WAIT before the unit aborts with err=1; 0 disables the watchdog.
- CNT_W, 16, width of the watchdog counter; TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  LSU can accept; high only in IDLE
- MemRead  in  1  load
- MemWrite  in  1  store; MemRead and MemWrite both high is illegal, and MemWrite wins
- MemOp  in  3  funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu; 111 is treated as d
- addr  in  64  execute final_result
- wdata  in  64  store data (busB)
- dmem_req_valid  out  1  memory request
- dmem_req_ready  in  1  memory accepts request
- dmem_req_addr  out  64  {addr[63:3],3'b0}
- dmem_req_wen  out  1  store
- dmem_req_wdata  out  64  wdata << (8*addr[2:0])
- dmem_req_wmask  out  8  byte strobe
- dmem_resp_valid  in  1  response (load data or store ack)
- dmem_resp_data  in  64  aligned doubleword
- out_valid  out  1  writeback value valid
- out_ready  in  1  writeback stage accepts
- rdata  out  64  writeback value
- misalign  out  1  access not naturally aligned
- err  out  1  watchdog timeout

Behaviour:
- Reset values: state IDLE; in_ready=1; dmem_req_valid=0, dmem_req_wen=0, dmem_req_addr=0, dmem_req_wdata=0, dmem_req_wmask=0; out_valid=0, rdata=0, misalign=0, err=0; counter=0.
- Reset mid-operation: all state is abandoned. A dmem_resp_valid arriving in IDLE or REQ is ignored.
- Accept: in_valid && in_ready at cycle N latches MemRead, MemWrite, MemOp, addr and wdata. After acceptance, inputs are don't-care.
- State IDLE, non-memory op (neither MemRead nor MemWrite): go to DONE. rdata=addr, out_valid=1 at N+1.
- State IDLE, misaligned memory op: go to DONE, no memory request, misalign=1, rdata=0.
  - h/hu: addr[0]!=0
  - w/wu: addr[1:0]!=0
  - d: addr[2:0]!=0
- State IDLE, aligned memory op: go to REQ. dmem_req_valid=1 from N+1.
- State REQ: request fields held stable while dmem_req_valid && !dmem_req_ready. On the handshake go to WAIT, drop req_valid the next cycle and clear the counter.
- State WAIT: on dmem_resp_valid go to DONE. The counter increments every cycle without a response. If TIMEOUT!=0 and counter==TIMEOUT-1 with no response, go to DONE with err=1 and rdata=0.
- Response in the same cycle as the timeout compare: the response wins and err=0.
- Load data: sh = dmem_resp_data >> (8*addr[2:0]).
  - b/h/w/d: sign-extend sh[7:0]/[15:0]/[31:0]/[63:0].
  - bu/hu/wu: zero-extend.
  - Stores: rdata=0.
- Write mask: size mask 0x01/0x03/0x0F/0xFF << addr[2:0]. Loads drive wmask=0 and wen=0.
- State DONE: out_valid=1 and rdata/misalign/err held until out_ready. On handshake go to IDLE; out_valid=0 and the flags clear the next cycle.
- Latency:
  - Bypass or misaligned: 1 cycle to out_valid.
  - Memory, zero-wait memory: req at N+1, resp at N+2, out_valid at N+3.
- Throughput: at most one instruction in flight. A new accept is possible the cycle after the output handshake.

Decomposition:
- Shared package holds:
  - state enum IDLE/REQ/WAIT/DONE
  - MemOp encodings MEMOP_B…MEMOP_WU
  - size-mask constants
- One sub-module, ysyx_22040386_lsu_align: purely combinational; maps (MemOp, addr[2:0], wdata, resp_data) to (wdata_shifted, wmask, load_ext, misalign). The FSM, counter and handshakes stay in the top.

Test Plan:
- Bypass:
  - Stimulus: MemRead=MemWrite=0, addr=0x8000_0010, out_ready=1.
  - Response: out_valid one cycle after accept, rdata=0x8000_0010, no dmem_req_valid.
- Load byte, signed and unsigned:
  - Stimulus: lb then lbu at addr=0x8000_0005; resp_data=0x0000_8000_0000_0000 (byte 5 = 0x80).
  - Response: req_addr=0x8000_0000; lb rdata=0xFFFF_FFFF_FFFF_FF80; lbu rdata=0x80.
- Store halfword with backpressure:
  - Stimulus: sh, addr=0x8000_0006, wdata=0x1234; dmem_req_ready low for 3 cycles.
  - Response: req fields stable for 4 cycles; wmask=0xC0; wdata=0x1234_0000_0000_0000; wen=1; rdata=0 after ack.
- Misaligned:
  - Stimulus: lw at addr=0x8000_0002.
  - Response: no memory request; out_valid at N+1 with misalign=1, rdata=0.
- Timeout:
  - Stimulus: TIMEOUT=4, ld aligned, no response.
  - Response: err=1 and out_valid after 4 WAIT cycles. A late resp_valid while in IDLE produces nothing.
- Reset mid-WAIT and output stall:
  - Stimulus: assert rst while in WAIT; separately, hold out_ready=0 for 5 cycles after a lwu.
  - Response: reset returns every output to its reset value the next cycle and in_ready=1. During the stall, rdata stays stable and in_ready stays 0.
